// File: rtl/dose_scheduler.sv
// Multi-slot medication dose scheduler. Matches the running wall clock against
// programmable dose times, queues matches and hands them one at a time to the
// dispenser actuator, flagging doses that are not confirmed in time.
module dose_scheduler #(
  parameter int unsigned NUM_SLOTS = 3,
  parameter int unsigned SLOT_W    = 2,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [4:0]           hours,
  input  logic [5:0]           minutes,
  input  logic [5:0]           seconds,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic [4:0]           cfg_hour,
  input  logic [5:0]           cfg_minute,
  input  logic                 cfg_en,
  output logic                 disp_valid,
  output logic [NUM_SLOTS-1:0] disp_ch,
  input  logic                 disp_done,
  output logic [NUM_SLOTS-1:0] missed,
  input  logic                 clr_missed,
  output logic [7:0]           dose_count,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StDispense, StCooldown} state_e;

  state_e               r_state, w_state_next;
  logic [4:0]           r_slot_hour [NUM_SLOTS];
  logic [5:0]           r_slot_min  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_slot_en;
  logic [NUM_SLOTS-1:0] r_pending, w_pending_next;
  logic [SLOT_W-1:0]    r_cur, w_cur_next;
  logic [7:0]           r_timer, w_timer_next;
  logic [NUM_SLOTS-1:0] r_missed, w_missed_next;
  logic [7:0]           r_count, w_count_next;

  logic [NUM_SLOTS-1:0] w_match;
  logic [NUM_SLOTS-1:0] w_cur_onehot;
  logic [SLOT_W-1:0]    w_low_idx;
  logic                 w_found;
  logic [7:0]           w_timer_inc;
  logic                 w_timeout;

  // Per-slot time match, evaluated only at the top of each minute.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      w_match[i] = tick && (seconds == 6'd0) && r_slot_en[i] &&
                   (r_slot_hour[i] == hours) && (r_slot_min[i] == minutes);
    end
  end

  // Lowest pending slot wins arbitration; one-hot decode of the slot in service.
  always_comb begin
    w_low_idx    = '0;
    w_found      = 1'b0;
    w_cur_onehot = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (r_pending[i] && !w_found) begin
        w_low_idx = SLOT_W'(i);
        w_found   = 1'b1;
      end
      w_cur_onehot[i] = (r_cur == SLOT_W'(i));
    end
  end

  // Timer value after this tick; timeout fires on the tick that reaches TIMEOUT_S.
  always_comb begin
    w_timer_inc = r_timer + 8'd1;
    w_timeout   = tick && (32'(w_timer_inc) == TIMEOUT_S);
  end

  // Next-state and output logic of the dispense FSM.
  always_comb begin
    w_state_next   = r_state;
    // A match on an already-pending slot is absorbed by the OR.
    w_pending_next = r_pending | w_match;
    w_cur_next     = r_cur;
    w_timer_next   = r_timer;
    w_missed_next  = clr_missed ? '0 : r_missed;
    w_count_next   = r_count;
    disp_valid     = 1'b0;
    disp_ch        = '0;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_cur_next   = w_low_idx;
          w_timer_next = '0;
          w_state_next = StDispense;
        end
      end
      StDispense: begin
        disp_valid = 1'b1;
        disp_ch    = w_cur_onehot;
        // Completion takes priority over a coincident timeout.
        if (disp_done) begin
          w_pending_next = w_pending_next & ~w_cur_onehot;
          if (r_count != 8'hFF) begin
            w_count_next = r_count + 8'd1;
          end
          w_state_next = StCooldown;
        end else if (tick) begin
          w_timer_next = w_timer_inc;
          if (w_timeout) begin
            // Set after the clear so a simultaneous clr_missed loses.
            w_missed_next  = w_missed_next | w_cur_onehot;
            w_pending_next = w_pending_next & ~w_cur_onehot;
            w_state_next   = StCooldown;
          end
        end
      end
      StCooldown: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers: queue, current slot, timer, flags and dose counter.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_pending <= '0;
      r_cur     <= '0;
      r_timer   <= '0;
      r_missed  <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_next;
      r_cur     <= w_cur_next;
      r_timer   <= w_timer_next;
      r_missed  <= w_missed_next;
      r_count   <= w_count_next;
    end
  end

  // Slot configuration; writes to nonexistent slots fall through the loop unmatched.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        r_slot_hour[i] <= (i == 0) ? 5'd8 : (i == 1) ? 5'd13 : (i == 2) ? 5'd20 : 5'd0;
        r_slot_min[i]  <= 6'd0;
        r_slot_en[i]   <= (i < 3);
      end
    end else if (cfg_we) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (cfg_slot == SLOT_W'(i)) begin
          r_slot_hour[i] <= cfg_hour;
          r_slot_min[i]  <= cfg_minute;
          r_slot_en[i]   <= cfg_en;
        end
      end
    end
  end

  assign missed     = r_missed;
  assign dose_count = r_count;
  assign busy       = (r_pending != '0) || (r_state != StIdle);

endmodule

// File: tb/tb_dose_scheduler.sv
// Self-checking bench for dose_scheduler: table of single-slot vectors, a
// scoreboard of expected dispense channels, and hand-written corner sequences.
module tb_dose_scheduler;

  localparam int unsigned NS = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned TO = 30;

  logic          CLOCK_50   = 1'b0;
  logic          reset      = 1'b0;
  logic          tick       = 1'b0;
  logic [4:0]    hours      = '0;
  logic [5:0]    minutes    = '0;
  logic [5:0]    seconds    = '0;
  logic          cfg_we     = 1'b0;
  logic [SW-1:0] cfg_slot   = '0;
  logic [4:0]    cfg_hour   = '0;
  logic [5:0]    cfg_minute = '0;
  logic          cfg_en     = 1'b0;
  logic          disp_valid;
  logic [NS-1:0] disp_ch;
  logic          disp_done  = 1'b0;
  logic [NS-1:0] missed;
  logic          clr_missed = 1'b0;
  logic [7:0]    dose_count;
  logic          busy;

  dose_scheduler #(
    .NUM_SLOTS (NS),
    .SLOT_W    (SW),
    .TIMEOUT_S (TO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tick       (tick),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .cfg_we     (cfg_we),
    .cfg_slot   (cfg_slot),
    .cfg_hour   (cfg_hour),
    .cfg_minute (cfg_minute),
    .cfg_en     (cfg_en),
    .disp_valid (disp_valid),
    .disp_ch    (disp_ch),
    .disp_done  (disp_done),
    .missed     (missed),
    .clr_missed (clr_missed),
    .dose_count (dose_count),
    .busy       (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [2:0] ch;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] sb_q[$];
  logic [4:0] m_hour [NS];
  logic [5:0] m_min  [NS];
  logic       m_en   [NS];
  int         exp_count = 0;
  logic       mon_prev  = 1'b0;
  vec_t       vecs [7];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_defaults();
    m_hour[0] = 5'd8;  m_hour[1] = 5'd13; m_hour[2] = 5'd20;
    for (int i = 0; i < int'(NS); i++) begin
      m_min[i] = 6'd0;
      m_en[i]  = 1'b1;
    end
    exp_count = 0;
  endtask

  // Push every slot the model says matches, lowest index first.
  task automatic model_match(input logic [4:0] h, input logic [5:0] m);
    for (int i = 0; i < int'(NS); i++) begin
      if (m_en[i] && m_hour[i] == h && m_min[i] == m) sb_q.push_back(3'(1 << i));
    end
  endtask

  task automatic do_tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hours = h; minutes = m; seconds = s; tick = 1'b1;
    if (s == 6'd0) model_match(h, m);
    step();
    tick = 1'b0;
  endtask

  task automatic cfg(input int slot, input logic [4:0] h, input logic [5:0] m, input logic en);
    cfg_we = 1'b1; cfg_slot = SW'(slot); cfg_hour = h; cfg_minute = m; cfg_en = en;
    if (slot < int'(NS)) begin
      m_hour[slot] = h; m_min[slot] = m; m_en[slot] = en;
    end
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    model_defaults();
  endtask

  // Called in the cycle after the matching tick: checks latency, channel and completion.
  task automatic serve(input string name, input logic [2:0] ch);
    check({name, "_lat"}, disp_valid, 0);
    step();
    check({name, "_valid"}, disp_valid, 1);
    check({name, "_ch"}, disp_ch, ch);
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    exp_count++;
    check({name, "_fall"}, disp_valid, 0);
    check({name, "_count"}, dose_count, exp_count);
    step();
    step();
  endtask

  task automatic expect_idle(input string name);
    step();
    step();
    check(name, {disp_valid, busy}, 0);
  endtask

  task automatic run_timeout(input logic done_on_last, input string name);
    do_tick(5'd20, 6'd0, 6'd0);
    step();
    check({name, "_valid"}, disp_valid, 1);
    check({name, "_ch"}, disp_ch, 3'b100);
    for (int t = 1; t < int'(TO); t++) begin
      do_tick(5'd20, 6'd0, 6'(t));
      step();
    end
    check({name, "_still_valid"}, disp_valid, 1);
    disp_done = done_on_last;
    do_tick(5'd20, 6'd0, 6'(TO));
    disp_done = 1'b0;
    check({name, "_valid_off"}, disp_valid, 0);
    check({name, "_busy_cool"}, busy, 1);
    if (done_on_last) begin
      exp_count++;
      check({name, "_missed"}, missed, 0);
    end else begin
      check({name, "_missed"}, missed, 3'b100);
    end
    check({name, "_count"}, dose_count, exp_count);
    step();
    check({name, "_busy_idle"}, busy, 0);
  endtask

  // Scoreboard: each new request must match the oldest expected channel.
  always @(negedge CLOCK_50) begin
    if (disp_valid && !mon_prev) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got request ch %0d, expected none", disp_ch);
      end else begin
        logic [2:0] req;
        req = sb_q.pop_front();
        check("sb_order", disp_ch, req);
      end
    end
    mon_prev = disp_valid;
  end

  initial begin
    vecs[0] = '{5'd8,  6'd0, 3'b001};
    vecs[1] = '{5'd13, 6'd0, 3'b010};
    vecs[2] = '{5'd20, 6'd0, 3'b100};
    vecs[3] = '{5'd8,  6'd1, 3'b000};
    vecs[4] = '{5'd7,  6'd0, 3'b000};
    vecs[5] = '{5'd12, 6'd0, 3'b000};
    vecs[6] = '{5'd0,  6'd0, 3'b000};

    do_reset();
    check("rst_valid", disp_valid, 0);
    check("rst_ch", disp_ch, 0);
    check("rst_missed", missed, 0);
    check("rst_count", dose_count, 0);
    check("rst_busy", busy, 0);

    // Default schedule.
    for (int i = 0; i < 7; i++) begin
      do_tick(vecs[i].h, vecs[i].m, 6'd0);
      if (vecs[i].ch != 3'b000) serve($sformatf("vec%0d", i), vecs[i].ch);
      else expect_idle($sformatf("vec%0d_idle", i));
    end

    // Reprogram slot1.
    cfg(1, 5'd9, 6'd30, 1'b1);
    do_tick(5'd9, 6'd30, 6'd0);
    serve("reprog", 3'b010);
    do_tick(5'd13, 6'd0, 6'd0);
    expect_idle("reprog_old_idle");

    // All three slots match together: served in order with 2 idle cycles between.
    do_reset();
    cfg(0, 5'd12, 6'd0, 1'b1);
    cfg(1, 5'd12, 6'd0, 1'b1);
    cfg(2, 5'd12, 6'd0, 1'b1);
    do_tick(5'd12, 6'd0, 6'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sim%0d_valid", k), disp_valid, 1);
      check($sformatf("sim%0d_ch", k), disp_ch, 1 << k);
      disp_done = 1'b1;
      step();
      disp_done = 1'b0;
      exp_count++;
      check($sformatf("sim%0d_gap1", k), disp_valid, 0);
      step();
      check($sformatf("sim%0d_gap2", k), disp_valid, 0);
      step();
    end
    check("sim_count", dose_count, 3);
    check("sim_busy", busy, 0);

    // Config write in the match cycle: the match uses the old slot value.
    do_reset();
    hours = 5'd13; minutes = 6'd0; seconds = 6'd0; tick = 1'b1;
    model_match(5'd13, 6'd0);
    cfg(1, 5'd13, 6'd0, 1'b0);
    tick = 1'b0;
    serve("cfg_coincide", 3'b010);
    do_tick(5'd13, 6'd0, 6'd0);
    expect_idle("cfg_coincide_after");

    // Timeout, clear, then done coinciding with the timeout tick.
    do_reset();
    run_timeout(1'b0, "tmo");
    clr_missed = 1'b1;
    step();
    clr_missed = 1'b0;
    check("clr_missed", missed, 0);
    run_timeout(1'b1, "tmo_done");

    // Reset mid-dispense restores outputs and the default schedule.
    do_reset();
    cfg(0, 5'd9, 6'd0, 1'b1);
    do_tick(5'd9, 6'd0, 6'd0);
    serve("pre_rst", 3'b001);
    do_tick(5'd13, 6'd0, 6'd0);
    step();
    check("mid_valid", disp_valid, 1);
    reset = 1'b0;
    step();
    check("mid_rst_valid", disp_valid, 0);
    check("mid_rst_count", dose_count, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b1;
    model_defaults();
    do_tick(5'd9, 6'd0, 6'd0);
    expect_idle("mid_rst_old_cfg");
    do_tick(5'd8, 6'd0, 6'd0);
    serve("mid_rst_default", 3'b001);

    // Disabled slot and out-of-range slot write.
    cfg(0, 5'd8, 6'd0, 1'b0);
    do_tick(5'd8, 6'd0, 6'd0);
    expect_idle("disabled");
    cfg(3, 5'd7, 6'd0, 1'b1);
    do_tick(5'd7, 6'd0, 6'd0);
    expect_idle("bad_slot");
    do_tick(5'd20, 6'd0, 6'd0);
    serve("bad_slot_keep", 3'b100);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dose_scheduler.md
# dose_scheduler

Programmable multi-slot medication dose scheduler; parametrised successor to the fixed 08:00/13:00/20:00 dispense-time decoder and dispense FSM. Compares the running HH:MM:SS clock against NUM_SLOTS run-time-configurable dose times, queues every match, and issues one dose at a time to the dispenser actuator through a valid/done handshake. Flags doses the actuator fails to confirm within a timeout. Sits between the clock counters and the motor/servo driver.

## Interface
Parameters:
- NUM_SLOTS, 3, number of dose slots (1..4)
- SLOT_W, 2, width of slot index (log2 ceiling of NUM_SLOTS, min 1)
- TIMEOUT_S, 30, seconds allowed for actuator confirmation (1..255)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-low
- tick  in  1  one-cycle pulse, once per second, from the seconds counter
- hours  in  5  current hour, 0..23
- minutes  in  6  current minute, 0..59
- seconds  in  6  current second, 0..59
- cfg_we  in  1  write strobe for slot configuration
- cfg_slot  in  SLOT_W  slot index to write
- cfg_hour  in  5  dose hour for the written slot
- cfg_minute  in  6  dose minute for the written slot
- cfg_en  in  1  enable bit for the written slot
- disp_valid  out  1  dose request to the actuator
- disp_ch  out  NUM_SLOTS  one-hot slot being dispensed; zero when disp_valid is 0
- disp_done  in  1  one-cycle actuator completion pulse
- missed  out  NUM_SLOTS  sticky per-slot missed-dose flags
- clr_missed  in  1  clears all missed flags
- dose_count  out  8  completed doses, saturates at 255
- busy  out  1  high when any dose is pending or in progress

## Operation
- Reset defaults: slot0 08:00 enabled; slot1 13:00 enabled; slot2 20:00 enabled; slots 3 and above 00:00 disabled.
- Reset output values: disp_valid=0, disp_ch=0, missed=0, dose_count=0, busy=0. The pending register and the timer are also cleared.
- Config: on cfg_we, if cfg_slot < NUM_SLOTS, the slot is written with {cfg_hour, cfg_minute, cfg_en}. Otherwise the write is ignored. No range check is applied to hour/minute; an out-of-range time never matches.
- Match: on a cycle with tick=1 and seconds=0, each enabled slot whose hour equals hours and whose minute equals minutes sets pending[i]. Several slots may match in the same cycle. A match on a slot whose pending bit is already set has no effect.
- The FSM has three states: IDLE, DISPENSE, COOLDOWN.
- IDLE: if pending is nonzero, select the lowest set index as cur, clear the timer, and go to DISPENSE.
- DISPENSE: disp_valid=1 and disp_ch=1<<cur.
  - On disp_done: clear pending[cur], increment dose_count (saturating), go to COOLDOWN.
  - Otherwise, on each tick the timer increments. When the timer equals TIMEOUT_S on a tick: set missed[cur], clear pending[cur], go to COOLDOWN.
- COOLDOWN: lasts one cycle, outputs deasserted, then IDLE.
- busy = (pending != 0) or (state != IDLE).
- clr_missed clears all missed flags. A missed flag set in the same cycle as clr_missed wins (the flag stays set).

## Timing
- Match to pending: pending bit is set at the edge ending the tick cycle.
- disp_valid rises 2 cycles after the matching tick cycle when IDLE.
- disp_done is sampled only in DISPENSE. It is ignored in IDLE and COOLDOWN.
- disp_valid falls the cycle after disp_done is accepted.
- Back-to-back queued doses are separated by exactly 2 cycles of disp_valid=0 (COOLDOWN plus IDLE).
- disp_done coinciding with the timeout tick: done wins. The dose is counted and missed is not set.
- A config write coinciding with a match cycle: the match uses the old slot value; the new value takes effect next cycle.
- Reconfiguring or disabling the slot in DISPENSE does not abort the dose in progress.
- A new match for the slot in DISPENSE re-sets its pending bit only after that slot's pending bit has been cleared (next day in normal use).
- Reset asserted mid-dispense: all outputs return to reset values at the next edge, and the schedule returns to the defaults.

## Test plan
- Defaults: reset, then drive 08:00:00 with tick. disp_valid=1 and disp_ch=3'b001 2 cycles later. Pulse disp_done: disp_valid=0 next cycle, dose_count=1.
- Reprogram: cfg_we slot1 to 09:30 enabled, then drive 09:30:00 with tick. disp_ch=3'b010. Driving 13:00:00 produces no request.
- Simultaneous: set all three slots to 12:00 and drive the match. Doses are served in order 001, 010, 100, each after disp_done, with 2 idle cycles between. Final dose_count=3.
- Timeout: match slot2 and never assert disp_done. After 30 ticks, missed=3'b100, disp_valid=0, busy=0. clr_missed returns missed to 0.
- Edge cases: disp_done in the same cycle as the 30th tick gives dose_count+1 and missed unchanged. Reset mid-DISPENSE gives disp_valid=0 next cycle, pending cleared, dose_count=0.
- Disabled/invalid: cfg_en=0 on slot0, then drive 08:00:00: no request. cfg_slot=3 with NUM_SLOTS=3: write ignored, schedule unchanged.
